// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared mult_op codes, XLEN and HI/LO sequencer state encoding
package mips_cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MT    = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// rtl/mips_cpu_muldiv_step.sv - one combinational shift-add / restoring-divide iteration
module mips_cpu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] addend;

    // Multiply keeps {partial_product, multiplier}; divide keeps {remainder, dividend}.
    always_comb begin
        addend   = acc[0] ? opnd : '0;
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh[XLEN-1:0] - opnd;
        q_bit    = 1'b0;
        acc_next = {sum, acc[XLEN-1:1]};
        if (is_div) begin
            q_bit    = (rem_sh >= {1'b0, opnd});
            // Quotient bit slot is left zero; the caller merges q_bit in.
            acc_next = {(q_bit ? diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// rtl/mips_cpu_muldiv_seq.sv - multi-cycle HI/LO multiply/divide unit with busy interlock
module mips_cpu_muldiv_seq #(
    parameter int XLEN = mips_cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            write,
    input  logic            mt_lo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);
    import mips_cpu_pkg::*;

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     state, state_next;
    mult_op_e          op_e;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_step, prod;
    logic [XLEN-1:0]   opnd, a_raw, a_mag, b_mag, res_hi, res_lo;
    logic              div_mode, neg_res, neg_rem, div0;
    logic              is_arith, op_signed, op_div, accept, q_bit;

    assign op_e = mult_op_e'(op);
    assign busy = (state != ST_IDLE);

    always_comb begin
        is_arith  = (op_e == OP_MULT) || (op_e == OP_MULTU) || (op_e == OP_DIV) || (op_e == OP_DIVU);
        op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
        op_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
        a_mag     = (op_signed && a[XLEN-1]) ? -a : a;
        b_mag     = (op_signed && b[XLEN-1]) ? -b : b;
        accept    = (state == ST_IDLE) && write && is_arith;
    end

    mips_cpu_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (div_mode),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_ITER;
            ST_ITER: if (cnt == CW'(XLEN - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Divide-by-zero bypasses sign fixup and returns the raw dividend in HI.
    always_comb begin
        prod = neg_res ? -acc : acc;
        {res_hi, res_lo} = prod;
        if (div_mode) begin
            if (div0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_lo = neg_res ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
                res_hi = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            div_mode <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        div_mode <= op_div;
                        opnd     <= op_div ? b_mag : a_mag;
                        acc      <= {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
                        neg_res  <= op_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem  <= op_signed && a[XLEN-1];
                        div0     <= (b == '0);
                        a_raw    <= a;
                        cnt      <= '0;
                    end else if (write && op_e == OP_MT) begin
                        if (mt_lo) lo <= a;
                        else       hi <= a;
                    end
                end
                ST_ITER: begin
                    acc <= acc_step | {{(2*XLEN-1){1'b0}}, q_bit};
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb/tb_mips_cpu_muldiv_seq.sv - directed self-checking bench with a cycle-level HI/LO model
module tb_mips_cpu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic        write = 1'b0, mt_lo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_cpu_muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .write (write),
        .mt_lo (mt_lo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] f_op, input logic [31:0] fa,
                                               input logic [31:0] fb);
        longint      sa, sb, sq, sr;
        logic [63:0] r;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        r  = '0;
        case (f_op)
            3'd1: r = sa * sb;
            3'd2: r = {32'b0, fa} * {32'b0, fb};
            3'd3, 3'd4: begin
                if (fb == 0) begin
                    r = {fa, 32'hFFFF_FFFF};
                end else if (f_op == 3'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end else begin
                    r = {fa % fb, fa / fb};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle-level model: an accepted op makes the unit busy for 33 cycles, then HI/LO update with done.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_rem;
    logic        m_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (write) begin
                if (op >= 3'd1 && op <= 3'd4) begin
                    m_pend <= ref_result(op, a, b);
                    m_rem  <= 33;
                end else if (op == 3'd5) begin
                    if (mt_lo) m_lo <= a;
                    else       m_hi <= a;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_hi",   {32'b0, hi},   {32'b0, m_hi});
            check("cyc_lo",   {32'b0, lo},   {32'b0, m_lo});
            check("cyc_busy", {63'b0, busy}, {63'b0, (m_rem != 0)});
            check("cyc_done", {63'b0, done}, {63'b0, m_done});
        end
    end

    task automatic drive(input logic [2:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tmt);
        op = t_op; a = ta; b = tb_v; mt_lo = tmt; write = 1'b1;
        @(negedge clk);
        write = 1'b0; op = 3'd0;
    endtask

    task automatic issue(input logic [2:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tmt);
        @(negedge clk);
        drive(t_op, ta, tb_v, tmt);
    endtask

    task automatic wait_done(input string name, output int bc);
        bit seen = 1'b0;
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, {63'b0, seen}, 64'd1);
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        check({name, "_hi"}, {32'b0, hi}, {32'b0, ehi});
        check({name, "_lo"}, {32'b0, lo}, {32'b0, elo});
    endtask

    initial begin
        int bc;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi",   {32'b0, hi},   64'd0);
        check("rst_lo",   {32'b0, lo},   64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu_max", bc);
        check("multu_busy_cycles", 64'(bc), 64'd33);
        expect_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("done_single_pulse", {63'b0, done}, 64'd0);

        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done("mult_neg", bc);
        expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("mult_min", bc);
        expect_hilo("mult_min", 32'h4000_0000, 32'h0000_0000);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg", bc);
        expect_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd4, 32'd100, 32'd0, 1'b0);
        wait_done("divu_zero", bc);
        check("divu_zero_busy_cycles", 64'(bc), 64'd33);
        expect_hilo("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF);

        issue(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);
        wait_done("div_zero", bc);
        expect_hilo("div_zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_ovf", bc);
        expect_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_hi",   {32'b0, hi},   64'h1234_5678);
        check("mthi_lo",   {32'b0, lo},   64'h8000_0000);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        check("mthi_done", {63'b0, done}, 64'd0);

        issue(3'd2, 32'd3, 32'd4, 1'b0);
        repeat (5) @(negedge clk);
        drive(3'd5, 32'h0000_AAAA, 32'd0, 1'b1);
        wait_done("mt_while_busy", bc);
        expect_hilo("mt_while_busy", 32'd0, 32'd12);

        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_hi",   {32'b0, hi},   64'd0);
        check("async_rst_lo",   {32'b0, lo},   64'd0);
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        wait_done("divu_after_rst", bc);
        expect_hilo("divu_after_rst", 32'd6, 32'd142);

        issue(3'd2, 32'd2, 32'd3, 1'b0);
        wait_done("b2b_first", bc);
        expect_hilo("b2b_first", 32'd0, 32'd6);
        drive(3'd4, 32'd9, 32'd4, 1'b0);
        wait_done("b2b_second", bc);
        check("b2b_second_busy_cycles", 64'(bc), 64'd33);
        expect_hilo("b2b_second", 32'd1, 32'd2);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_cpu_muldiv_seq.md
Name: mips_cpu_muldiv_seq

Overview:
Multi-cycle HI/LO multiply/divide responder that serves the ALU's mult_op/write request interface. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and iterates a radix-2 shift-add multiplier or restoring divider over 32 cycles. Holds the architectural HI/LO registers and exposes them continuously for the ALU's MFHI/MFLO result mux. Signals busy so the pipeline can interlock.

Parameters:
XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
a  input  XLEN  rs operand (multiplicand / dividend / MTHI-MTLO source).
b  input  XLEN  rt operand (multiplier / divisor).
op  input  3  mult_op code (package enum).
write  input  1  request strobe; qualifies op for one cycle.
mt_lo  input  1  with op=MTHI code: 0 writes HI, 1 writes LO.
hi  output  XLEN  architectural HI register.
lo  output  XLEN  architectural LO register.
busy  output  1  operation in flight; high in ITER and FIX.
done  output  1  one-cycle pulse when HI/LO take an arithmetic result.

Behaviour:
- Op encoding: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI/MTLO (selected by mt_lo), 110 MFHI, 111 MFLO. MFHI, MFLO and NOP have no effect here.
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, done=0, counter=0. Applies at any time, including mid-operation; the in-flight result is discarded.
- FSM states: IDLE, ITER, FIX. busy = (state != IDLE), combinational from state.
- IDLE with write=1 and op in 001..100:
  - latch operand magnitudes (absolute values for signed ops; raw for unsigned);
  - latch result-sign flags: product sign = sign(a) xor sign(b); quotient sign = sign(a) xor sign(b); remainder sign = sign(a);
  - latch a divide-by-zero flag;
  - cnt=0, go to ITER.
- ITER: one iteration per clock, cnt increments. After the 32nd iteration (cnt==XLEN-1), go to FIX.
  - Multiply: 64-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring; shift the remainder in, trial-subtract the divisor, set the quotient bit if no borrow.
- FIX: apply two's-complement negation per the sign flags, write hi/lo, assert done for this cycle's output (done registered, high exactly one cycle), go to IDLE.
- Latency: hi/lo hold new values starting 34 clocks after the accepting edge (1 accept + 32 ITER + 1 FIX edge). busy is high for 33 cycles.
- Result mapping:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (DIV and DIVU): normal latency; lo = 0xFFFFFFFF, hi = a (raw operand); no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap).
- MTHI/MTLO in IDLE: target register updated at the next edge. No busy, no done.
- Any request (including MT and new arithmetic) while busy is ignored; hi/lo keep their old values until FIX. The CPU must stall on busy.
- hi/lo are never partially updated; they change only at the FIX edge or an MT edge.

Decomposition:
- Shared package mips_cpu_pkg: mult_op enum (codes above), XLEN constant, muldiv FSM state enum.
- One natural sub-module: mips_cpu_muldiv_step, a combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
- Top module owns the FSM, counter, sign fixup and HI/LO registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once at edge 34.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next edge, busy/done stay 0. MULTU 3x4 then MTLO 0xAAAA during busy -> MTLO ignored; lo=12, hi=0.
- DIVU 1000/7 started, reset pulsed low at cycle 10 -> hi=lo=0, busy=0 immediately. Fresh DIVU 1000/7 after release -> lo=142, hi=6.
- Back-to-back: MULTU 2x3 followed by a DIVU 9/4 request held in the cycle after done -> second op accepted; lo=2, hi=1 after a further 34 edges.
